// File: rtl/json_drive_sender.sv
// Drive-command to JSON frame sender: latches {direction, speed}, formats a 28-byte
// {"T":1,"L":s0.DD,"R":s0.DD}\n frame and shifts it out on an 8N1 UART TX line.
module json_drive_sender #(
  parameter int CLKS_PER_BIT  = 434,
  parameter int BITS_N        = 8,
  parameter int SPEED_W       = 3,
  parameter int SPEED_STEP    = 5,
  parameter int REPEAT_CYCLES = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         direction,
  input  logic [SPEED_W-1:0] speed,
  output logic               uart_out,
  output logic               busy,
  output logic               done,
  output logic [4:0]         byte_idx
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (BITS_N > 1) ? $clog2(BITS_N) : 1;
  localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(BITS_N - 1);
  localparam logic [4:0]    BYTE_LAST = 5'd27;
  localparam bit            HB_EN     = (REPEAT_CYCLES > 0);
  // The counter reads 1 in the first idle cycle after done, so firing at
  // REPEAT_CYCLES-1 puts the resent start bit REPEAT_CYCLES cycles after done.
  localparam logic [31:0]   HB_LIM    = HB_EN ? 32'(REPEAT_CYCLES - 1) : 32'd0;

  logic [2:0]         state_q, state_d;
  logic [CW-1:0]      clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [4:0]         byte_q, byte_d;
  logic [2:0]         dir_q, dir_d;
  logic [SPEED_W-1:0] spd_q, spd_d;
  logic               has_cmd_q, has_cmd_d;
  logic [31:0]        hb_q, hb_d;
  logic               uart_q, uart_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;
  logic [4:0]         idx_q, idx_d;
  logic               accept_s;
  logic               fire_s;
  logic [BITS_N-1:0]  char_s;

  function automatic logic [7:0] frame_byte(input logic [4:0] idx,
                                            input logic [2:0] dir,
                                            input logic [SPEED_W-1:0] spd);
    int         mag;
    logic [7:0] sgn_l;
    logic [7:0] sgn_r;
    logic [7:0] tens;
    logic [7:0] ones;
    logic [7:0] ch;
    mag   = int'(spd) * SPEED_STEP;
    sgn_l = 8'h20;
    sgn_r = 8'h20;
    case (dir)
      3'd1: sgn_l = 8'h20;
      3'd2: begin sgn_l = 8'h2D; sgn_r = 8'h2D; end
      3'd3: sgn_l = 8'h2D;
      3'd4: sgn_r = 8'h2D;
      default: mag = 0;
    endcase
    tens = 8'h30 + 8'(mag / 10);
    ones = 8'h30 + 8'(mag % 10);
    case (idx)
      5'd0:  ch = 8'h7B;
      5'd1:  ch = 8'h22;
      5'd2:  ch = 8'h54;
      5'd3:  ch = 8'h22;
      5'd4:  ch = 8'h3A;
      5'd5:  ch = 8'h31;
      5'd6:  ch = 8'h2C;
      5'd7:  ch = 8'h22;
      5'd8:  ch = 8'h4C;
      5'd9:  ch = 8'h22;
      5'd10: ch = 8'h3A;
      5'd11: ch = sgn_l;
      5'd12: ch = 8'h30;
      5'd13: ch = 8'h2E;
      5'd14: ch = tens;
      5'd15: ch = ones;
      5'd16: ch = 8'h2C;
      5'd17: ch = 8'h22;
      5'd18: ch = 8'h52;
      5'd19: ch = 8'h22;
      5'd20: ch = 8'h3A;
      5'd21: ch = sgn_r;
      5'd22: ch = 8'h30;
      5'd23: ch = 8'h2E;
      5'd24: ch = tens;
      5'd25: ch = ones;
      5'd26: ch = 8'h7D;
      5'd27: ch = 8'h0A;
      default: ch = 8'h20;
    endcase
    return ch;
  endfunction

  // Next-state logic; outputs are derived from the next state so they are registered.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    dir_d     = dir_q;
    spd_d     = spd_q;
    has_cmd_d = has_cmd_q;
    hb_d      = hb_q;
    accept_s  = (state_q == S_IDLE) && ready_q && cmd_valid;
    fire_s    = HB_EN && (state_q == S_IDLE) && has_cmd_q && (hb_q >= HB_LIM);

    case (state_q)
      S_IDLE: begin
        if (accept_s || fire_s) begin
          if (accept_s) begin
            dir_d     = direction;
            spd_d     = speed;
            has_cmd_d = 1'b1;
          end else begin
            has_cmd_d = has_cmd_q;
          end
          state_d   = S_START;
          clk_cnt_d = '0;
          bit_d     = '0;
          byte_d    = 5'd0;
          hb_d      = 32'd0;
        end else if (hb_q < HB_LIM) begin
          hb_d = hb_q + 32'd1;
        end else begin
          hb_d = hb_q;
        end
      end
      S_START: begin
        if (clk_cnt_q == CLK_LAST) begin
          state_d   = S_DATA;
          clk_cnt_d = '0;
          bit_d     = '0;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (clk_cnt_q == CLK_LAST) begin
          clk_cnt_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (clk_cnt_q == CLK_LAST) begin
          clk_cnt_d = '0;
          if (byte_q == BYTE_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_START;
            byte_d  = byte_q + 5'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        hb_d    = 32'd1;
      end
      default: state_d = S_IDLE;
    endcase

    char_s = BITS_N'(frame_byte(byte_d, dir_d, spd_d));
    case (state_d)
      S_START: uart_d = 1'b0;
      S_DATA:  uart_d = char_s[bit_d];
      default: uart_d = 1'b1;
    endcase
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    ready_d = (state_d == S_IDLE);
    if ((state_d == S_START) || (state_d == S_DATA) || (state_d == S_STOP)) begin
      idx_d = byte_d;
    end else begin
      idx_d = 5'd0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_q     <= '0;
      byte_q    <= 5'd0;
      dir_q     <= 3'd0;
      spd_q     <= '0;
      has_cmd_q <= 1'b0;
      hb_q      <= 32'd0;
      uart_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
      idx_q     <= 5'd0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      dir_q     <= dir_d;
      spd_q     <= spd_d;
      has_cmd_q <= has_cmd_d;
      hb_q      <= hb_d;
      uart_q    <= uart_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      idx_q     <= idx_d;
    end
  end

  assign uart_out  = uart_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cmd_ready = ready_q;
  assign byte_idx  = idx_q;

endmodule
